// File: rtl/ddr3_wr_port_arbiter.sv
// Round-robin arbiter sharing one single-beat DDR3 Avalon-MM write port among
// NUM_PORTS requesters; the granted port's write passes through combinationally.
module ddr3_wr_port_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int MAX_CONSEC = 8
) (
  input  logic                     ddr3_clk,
  input  logic                     ddr3clk_reset,
  input  logic [NUM_PORTS-1:0]     req_write,
  input  logic [NUM_PORTS*27-1:0]  req_address,
  input  logic [NUM_PORTS*256-1:0] req_writedata,
  input  logic [NUM_PORTS*32-1:0]  req_byteenable,
  output logic [NUM_PORTS-1:0]     req_waitrequest,
  output logic [26:0]              ddr3_write_address,
  output logic [255:0]             ddr3_write_data,
  output logic [31:0]              ddr3_byteenable,
  output logic                     ddr3_write,
  input  logic                     ddr3_waitrequest,
  output logic [NUM_PORTS-1:0]     grant_onehot,
  output logic                     write_accepted
);

  localparam int         IDX_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [7:0] MAX_CNT = 8'(MAX_CONSEC);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_gnt_idx, w_gnt_nxt;
  logic [IDX_W-1:0] r_last_idx, w_last_nxt;
  logic [7:0]       r_consec_cnt, w_cnt_nxt;
  logic [IDX_W-1:0] w_pick_idx;
  logic [IDX_W-1:0] w_cand_idx;
  int               w_cand;
  logic             w_granted, w_write, w_accept, w_any_req, w_other_req;
  logic [NUM_PORTS-1:0] w_gnt_onehot;

  logic [26:0]  w_addr_arr [NUM_PORTS];
  logic [255:0] w_data_arr [NUM_PORTS];
  logic [31:0]  w_be_arr   [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign w_addr_arr[p] = req_address[27*p +: 27];
    assign w_data_arr[p] = req_writedata[256*p +: 256];
    assign w_be_arr[p]   = req_byteenable[32*p +: 32];
  end

  assign w_gnt_onehot = {{(NUM_PORTS-1){1'b0}}, 1'b1} << r_gnt_idx;
  assign w_any_req    = |req_write;
  assign w_other_req  = |(req_write & ~w_gnt_onehot);

  // Scan downward so the candidate closest after last_idx is the one that sticks.
  always_comb begin
    w_pick_idx = '0;
    w_cand     = 0;
    w_cand_idx = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      w_cand     = int'(r_last_idx) + k;
      w_cand     = (w_cand >= NUM_PORTS) ? (w_cand - NUM_PORTS) : w_cand;
      w_cand_idx = w_cand[IDX_W-1:0];
      w_pick_idx = req_write[w_cand_idx] ? w_cand_idx : w_pick_idx;
    end
  end

  // Port-facing and controller-facing outputs; reset forces the idle view.
  always_comb begin
    w_granted          = (r_state == ST_GRANT) && !ddr3clk_reset;
    ddr3_write_address = w_addr_arr[r_gnt_idx];
    ddr3_write_data    = w_data_arr[r_gnt_idx];
    ddr3_byteenable    = w_be_arr[r_gnt_idx];
    if (w_granted) begin
      w_write         = req_write[r_gnt_idx];
      grant_onehot    = w_gnt_onehot;
      req_waitrequest = ~w_gnt_onehot | (w_gnt_onehot & {NUM_PORTS{ddr3_waitrequest}});
    end else begin
      w_write         = 1'b0;
      grant_onehot    = '0;
      req_waitrequest = '1;
    end
    w_accept       = w_write && !ddr3_waitrequest;
    ddr3_write     = w_write;
    write_accepted = w_accept;
  end

  // Next-state: grant selection, forced rotation and release on idle grantee.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt_idx;
    w_last_nxt  = r_last_idx;
    w_cnt_nxt   = r_consec_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_gnt_nxt   = w_pick_idx;
          w_cnt_nxt   = 8'd0;
          w_state_nxt = ST_GRANT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (w_accept) begin
          w_cnt_nxt = r_consec_cnt + 8'd1;
          if ((r_consec_cnt + 8'd1) == MAX_CNT) begin
            w_last_nxt  = r_gnt_idx;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_GRANT;
          end
        end else if (!req_write[r_gnt_idx] && w_other_req) begin
          w_last_nxt  = r_gnt_idx;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_GRANT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State registers; last_idx starts at the top port so port 0 wins first.
  always_ff @(posedge ddr3_clk) begin
    if (ddr3clk_reset) begin
      r_state      <= ST_IDLE;
      r_gnt_idx    <= '0;
      r_last_idx   <= IDX_W'(NUM_PORTS - 1);
      r_consec_cnt <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_gnt_idx    <= w_gnt_nxt;
      r_last_idx   <= w_last_nxt;
      r_consec_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: doc/ddr3_wr_port_arbiter.md
Name: ddr3_wr_port_arbiter

Overview:
- Round-robin arbiter that shares one DDR3 Avalon-MM write port (27-bit word address, 256-bit data, 32-bit byteenable) between NUM_PORTS pixel writers, e.g. one gray remap writer per camera.
- Single-beat writes only.
- The granted requester's write signals pass to DDR3 combinationally. All others see waitrequest high.
- Sits between the per-camera DDR3 writers and the DDR3 controller write port, in the ddr3_clk domain.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8).
- MAX_CONSEC, 8, maximum accepted writes per grant before forced rotation (1..255).

Ports:
- ddr3_clk  in  1  clock.
- ddr3clk_reset  in  1  synchronous, active-high reset.
- req_write  in  NUM_PORTS  per-port write request. Held until that port's waitrequest is low.
- req_address  in  NUM_PORTS*27  packed word addresses; port i at [27i+26:27i].
- req_writedata  in  NUM_PORTS*256  packed write data.
- req_byteenable  in  NUM_PORTS*32  packed byteenables.
- req_waitrequest  out  NUM_PORTS  per-port waitrequest.
- ddr3_write_address  out  27  to controller.
- ddr3_write_data  out  256  to controller.
- ddr3_byteenable  out  32  to controller.
- ddr3_write  out  1  to controller.
- ddr3_waitrequest  in  1  from controller.
- grant_onehot  out  NUM_PORTS  current grant; all zero when idle.
- write_accepted  out  1  one-cycle pulse per accepted DDR3 write.

Behaviour:
- Two states: ST_IDLE and ST_GRANT.
- Registers:
  - gnt_idx, width clog2(NUM_PORTS).
  - last_idx.
  - consec_cnt, 8 bits.
- Reset: state=ST_IDLE, gnt_idx=0, last_idx=NUM_PORTS-1 (so port 0 wins first), consec_cnt=0.
- Outputs during reset and in ST_IDLE:
  - ddr3_write=0, grant_onehot=0, write_accepted=0.
  - req_waitrequest all ones.
  - address/data/byteenable = port gnt_idx's values (don't-care).
- ST_IDLE:
  - If any req_write bit is set, pick the first set bit searching last_idx+1, last_idx+2, … with wrap modulo NUM_PORTS.
  - Load gnt_idx with it, clear consec_cnt, go to ST_GRANT.
  - The decision takes one cycle; the first DDR3 write is presented the cycle after the request is seen.
- ST_GRANT, combinational:
  - ddr3_write = req_write[gnt_idx].
  - Address/data/byteenable muxed from gnt_idx.
  - req_waitrequest[gnt_idx] = ddr3_waitrequest; all other bits = 1.
  - grant_onehot = 1<<gnt_idx.
  - write_accepted = ddr3_write && !ddr3_waitrequest.
- ST_GRANT, sequential:
  - On accept: consec_cnt++. If consec_cnt+1 == MAX_CONSEC, set last_idx=gnt_idx and go to ST_IDLE (forced rotation, even if no other request).
  - Else if req_write[gnt_idx]=0 and any other port requests: set last_idx=gnt_idx and go to ST_IDLE.
  - Else if req_write[gnt_idx]=0 and no other request: stay parked in ST_GRANT; consec_cnt is unchanged.
  - The grant never changes while the granted port holds write high with waitrequest high. No request is dropped or duplicated.
- Fairness: with all ports continuously requesting, no port waits more than (NUM_PORTS-1)*(MAX_CONSEC+1) accepted-write slots.
- Reset mid-transaction: returns to ST_IDLE next cycle with ddr3_write=0. The in-flight write is abandoned, not replayed.
- ddr3_write and waitrequest are never registered by this block. Zero-cycle throughput loss within a grant; one bubble cycle per grant change.

Test Plan:
- NUM_PORTS=4: only port 2 requests, address 0x0001234 → grant_onehot=0100 one cycle later; ddr3_write_address=0x0001234; write_accepted pulses once; req_waitrequest=1011 during the grant.
- All four ports request continuously, MAX_CONSEC=1 → accepted-write order 0,1,2,3,0,1,…; an idle bubble between each; a 16-write count gives exactly 4 per port.
- MAX_CONSEC=8, ports 0 and 1 requesting continuously → 8 writes from port 0, one idle cycle, then 8 from port 1; consec_cnt resets each grant.
- ddr3_waitrequest held high 5 cycles with port 1 granted and port 3 requesting → grant_onehot stays 0010; ddr3 address/data stable; port 3 sees waitrequest=1 throughout.
- Port 0 drops write after 3 writes while port 3 requests → ST_IDLE then grant 1000. If no other request, port 0 stays parked and its next write is accepted with no bubble.
- Reset asserted while port 2 is stalled by waitrequest → next cycle ddr3_write=0, grant_onehot=0; after release port 0 wins first.
